ps2_packet_framer: RTL and testbench

Parametrised PS/2-style packet framer that sits after the byte receiver in the mouse/keyboard input path. It scans a validated byte stream for a packet start byte, identified by a sync bit. It then collects a configurable number of bytes, pulses `done` and presents the whole packet in parallel. Unlike the fixed three-byte framer, it accepts gapped input through a valid strobe, supports any packet length from 2 to 8 bytes, and abandons a stalled packet after a programmable idle timeout.

---
 rtl/ps2_framer_pkg.sv | 9 +
 rtl/ps2_gap_timer.sv | 23 ++
 rtl/ps2_packet_framer.sv | 81 ++++++++
 tb/tb_ps2_packet_framer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ps2_framer_pkg.sv
// ps2_framer_pkg: shared state type, byte width and gap-counter sizing
// for the PS/2 packet framer.
package ps2_framer_pkg;
   localparam int BYTE_W = 8;
   typedef enum logic [1:0] {SEARCH, COLLECT, DONE} state_t;
   function automatic int gap_w(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction
endpackage

// File: rtl/ps2_gap_timer.sv
// ps2_gap_timer: saturating idle-cycle counter for a packet in progress;
// expire flags the idle edge on which the count reaches TIMEOUT.
module ps2_gap_timer
   import ps2_framer_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic expire
);
   localparam int W = gap_w(TIMEOUT);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc && cnt != W'(TIMEOUT)) cnt <= cnt + 1'b1;
   end
   // Fires on the edge that would bring the count to TIMEOUT, so the abort lands with it.
   assign expire = inc && (cnt >= W'(TIMEOUT - 1));
endmodule

// File: rtl/ps2_packet_framer.sv
// ps2_packet_framer: finds a sync-marked start byte in a gapped byte stream,
// collects PKT_BYTES bytes and presents them in parallel, aborting on idle timeout.
module ps2_packet_framer
   import ps2_framer_pkg::*;
#(
   parameter int PKT_BYTES = 3,
   parameter int SYNC_BIT  = 3,
   parameter int TIMEOUT   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [BYTE_W-1:0]             din,
   input  logic                          din_valid,
   output logic                          done,
   output logic [BYTE_W*PKT_BYTES-1:0]   pkt,
   output logic                          err
);
   localparam int IW = $clog2(PKT_BYTES);
   localparam logic [IW-1:0] LAST = IW'(PKT_BYTES - 1);
   state_t state;
   logic [IW-1:0] idx;
   logic [PKT_BYTES-1:0][BYTE_W-1:0] buffer, merged;
   logic expire;
   // Slot 0 lives in the MSBs, so slot n maps to packed element LAST-n.
   always_comb begin
      merged = buffer;
      merged[LAST - idx] = din;
   end
   if (TIMEOUT != 0) begin : g_timer
      ps2_gap_timer #(.TIMEOUT(TIMEOUT)) u_timer (
         .clk    (clk),
         .reset  (reset),
         .clr    (state != COLLECT || din_valid),
         .inc    (state == COLLECT && !din_valid),
         .expire (expire)
      );
   end else begin : g_no_timer
      assign expire = 1'b0;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= SEARCH;
         idx    <= '0;
         buffer <= '0;
         pkt    <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            COLLECT: begin
               if (din_valid) begin
                  buffer <= merged;
                  if (idx == LAST) begin
                     pkt   <= merged;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else if (expire) begin
                  err   <= 1'b1;
                  idx   <= '0;
                  state <= SEARCH;
               end
            end
            default: begin
               if (din_valid && din[SYNC_BIT]) begin
                  buffer[LAST] <= din;
                  idx          <= IW'(1);
                  state        <= COLLECT;
               end else begin
                  idx   <= '0;
                  state <= SEARCH;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ps2_packet_framer.sv
// tb_ps2_packet_framer: four framer configurations share one input stream and
// are checked every cycle against a queue-based packet model.
module tb_ps2_packet_framer;
   localparam int NB [4] = '{3, 3, 4, 2};
   localparam int SB [4] = '{3, 3, 7, 0};
   localparam int TO [4] = '{16, 4, 16, 0};
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [7:0] din = '0;
   logic din_valid = 1'b0;
   logic done_a [4];
   logic err_a [4];
   logic [63:0] pkt_a [4];
   logic [23:0] pkt0, pkt1;
   logic [31:0] pkt2;
   logic [15:0] pkt3;
   int checks = 0;
   int failures = 0;
   logic [7:0] q [4][$];
   int gap [4];
   logic [63:0] exp_pkt [4];
   logic exp_done [4];
   logic exp_err [4];

   always #5 clk = ~clk;

   ps2_packet_framer u0 (.clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
      .done(done_a[0]), .pkt(pkt0), .err(err_a[0]));
   ps2_packet_framer #(.PKT_BYTES(3), .SYNC_BIT(3), .TIMEOUT(4)) u1 (.clk(clk), .reset(reset),
      .din(din), .din_valid(din_valid), .done(done_a[1]), .pkt(pkt1), .err(err_a[1]));
   ps2_packet_framer #(.PKT_BYTES(4), .SYNC_BIT(7), .TIMEOUT(16)) u2 (.clk(clk), .reset(reset),
      .din(din), .din_valid(din_valid), .done(done_a[2]), .pkt(pkt2), .err(err_a[2]));
   ps2_packet_framer #(.PKT_BYTES(2), .SYNC_BIT(0), .TIMEOUT(0)) u3 (.clk(clk), .reset(reset),
      .din(din), .din_valid(din_valid), .done(done_a[3]), .pkt(pkt3), .err(err_a[3]));

   assign pkt_a[0] = 64'(pkt0);
   assign pkt_a[1] = 64'(pkt1);
   assign pkt_a[2] = 64'(pkt2);
   assign pkt_a[3] = 64'(pkt3);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("done%0d", i), 64'(done_a[i]), 64'(exp_done[i]));
         chk($sformatf("err%0d", i), 64'(err_a[i]), 64'(exp_err[i]));
         chk($sformatf("pkt%0d", i), pkt_a[i], exp_pkt[i]);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         q[i].delete();
         gap[i] = 0;
         exp_pkt[i] = '0;
         exp_done[i] = 1'b0;
         exp_err[i] = 1'b0;
      end
   endtask

   // Packet-level view: a packet is a queue that opens on a sync byte, fills
   // with any byte, and is dropped after TO consecutive idle cycles.
   task automatic model(input logic v, input logic [7:0] d);
      for (int i = 0; i < 4; i++) begin
         exp_done[i] = 1'b0;
         exp_err[i] = 1'b0;
         if (v) begin
            if (q[i].size() != 0 || d[SB[i]]) q[i].push_back(d);
            gap[i] = 0;
            if (q[i].size() == NB[i]) begin
               exp_pkt[i] = '0;
               for (int k = 0; k < q[i].size(); k++) exp_pkt[i] = (exp_pkt[i] << 8) | 64'(q[i][k]);
               exp_done[i] = 1'b1;
               q[i].delete();
            end
         end else if (q[i].size() != 0) begin
            gap[i]++;
            if (TO[i] != 0 && gap[i] == TO[i]) begin
               q[i].delete();
               gap[i] = 0;
               exp_err[i] = 1'b1;
            end
         end
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      din_valid = v;
      din = d;
      @(posedge clk);
      model(v, d);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 8'h00);
   endtask

   initial begin
      logic v;
      int phase;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      reset = 1'b0;

      step(1, 8'h08); step(1, 8'h12); step(1, 8'h34);
      chk("t1_done", 64'(done_a[0]), 64'd1);
      chk("t1_pkt", pkt_a[0], 64'h081234);
      idle(20);

      step(1, 8'h00); step(1, 8'h07); step(1, 8'h08); step(1, 8'hAA); step(1, 8'hBB);
      chk("t2_pkt", pkt_a[0], 64'h08AABB);
      idle(20);

      step(1, 8'h08); step(1, 8'h01); step(1, 8'h02);
      chk("t3_pkt_a", pkt_a[0], 64'h080102);
      step(1, 8'h09); step(1, 8'h03);
      chk("t3_gap_done", 64'(done_a[0]), 64'd0);
      step(1, 8'h04);
      chk("t3_done_b", 64'(done_a[0]), 64'd1);
      chk("t3_pkt_b", pkt_a[0], 64'h090304);
      idle(20);

      step(1, 8'h08); step(1, 8'h11);
      idle(3);
      chk("t4_no_err_yet", 64'(err_a[1]), 64'd0);
      idle(1);
      chk("t4_err", 64'(err_a[1]), 64'd1);
      chk("t4_pkt_hold", pkt_a[1], 64'h090304);
      step(1, 8'h22);
      chk("t4_discard", 64'(done_a[1]), 64'd0);
      idle(20);

      step(1, 8'h08); idle(3); step(1, 8'h11); idle(3); step(1, 8'h22);
      chk("t5_done", 64'(done_a[1]), 64'd1);
      chk("t5_pkt", pkt_a[1], 64'h081122);
      idle(20);

      step(1, 8'h81); step(1, 8'h0A); step(1, 8'h0B); step(1, 8'h0C);
      chk("t6_pkt_pre", pkt_a[2], 64'h810A0B0C);
      idle(20);
      step(1, 8'h80); step(1, 8'h01); step(1, 8'h02);
      #2 reset = 1'b1;
      #1 model_reset();
      check_all();
      chk("t6_async_pkt", pkt_a[2], 64'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      step(1, 8'h81); step(1, 8'h0A); step(1, 8'h0B); step(1, 8'h0C);
      chk("t6_pkt_post", pkt_a[2], 64'h810A0B0C);

      for (int k = 0; k < 900; k++) begin
         phase = (k / 100) % 3;
         v = (phase == 0) ? 1'b1 :
             (phase == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
         step(v, 8'($urandom_range(0, 255)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
